// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm_arb data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } dm_arb_state_t;

  localparam logic DM_ARB_P0         = 1'b0;
  localparam logic DM_ARB_P1         = 1'b1;
  localparam int   DM_ARB_LOCK_CNT_W = 4;

endpackage

// File: rtl/dm_arb_pick2.sv
// Combinational 2-way pick for dm_arb. The owner of a lock is the only candidate;
// otherwise ties go round robin, or to port 0 when DM_ARB_FIXED_PRIO_EN is defined.
module dm_arb_pick2
  import dm_arb_pkg::*;
(
  input  logic          req0,
  input  logic          req1,
  input  logic          last,
  input  dm_arb_state_t state,
  output logic          gnt0,
  output logic          gnt1
);

`ifdef DM_ARB_FIXED_PRIO_EN
  logic unused_last_s;
  assign unused_last_s = last;
`endif

  // Pick the winner for this cycle from requests, ownership and tie history.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      OWN0: gnt0 = req0;
      OWN1: gnt1 = req1;
      default: begin
        if (req0 && req1) begin
`ifdef DM_ARB_FIXED_PRIO_EN
          gnt0 = 1'b1;
          gnt1 = 1'b0;
`else
          gnt0 = (last == DM_ARB_P1);
          gnt1 = (last == DM_ARB_P0);
`endif
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
  end

endmodule

// File: rtl/dm_arb.sv
// Two-port arbiter/sequencer in front of the single-ported data memory DM.
// Optional fixed tie priority for port 0 via DM_ARB_FIXED_PRIO_EN (see dm_arb_pick2).
module dm_arb
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam logic [DM_ARB_LOCK_CNT_W-1:0] CNT_ZERO_C = {DM_ARB_LOCK_CNT_W{1'b0}};
  localparam logic [DM_ARB_LOCK_CNT_W-1:0] CNT_ONE_C  = {{(DM_ARB_LOCK_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DM_ARB_LOCK_CNT_W-1:0] CNT_MAX_C  = DM_ARB_LOCK_CNT_W'(MAX_LOCK);
  localparam logic                         LOCK_EN_C  = (MAX_LOCK > 1);

  dm_arb_state_t                state_r, state_nxt_s;
  logic                         last_r, last_nxt_s;
  logic [DM_ARB_LOCK_CNT_W-1:0] lock_cnt_r, lock_cnt_nxt_s;
  logic                         pick0_s, pick1_s;
  logic                         gnt0_s, gnt1_s, gnt_any_s;
  logic                         gnt_port_s, gnt_we_s, gnt_lock_s, own_lock_s;

  dm_arb_pick2 u_pick (
    .req0  (p0_req),
    .req1  (p1_req),
    .last  (last_r),
    .state (state_r),
    .gnt0  (pick0_s),
    .gnt1  (pick1_s)
  );

  // Nothing is granted while reset is held.
  assign gnt0_s     = pick0_s & ~rst;
  assign gnt1_s     = pick1_s & ~rst;
  assign gnt_any_s  = gnt0_s | gnt1_s;
  assign gnt_port_s = gnt1_s ? DM_ARB_P1 : DM_ARB_P0;
  assign gnt_we_s   = gnt1_s ? p1_we : p0_we;
  assign gnt_lock_s = gnt1_s ? p1_lock : p0_lock;
  assign own_lock_s = (state_r == OWN1) ? p1_lock : p0_lock;

  // State register: ownership, tie history and burst length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      last_r     <= DM_ARB_P1;
      lock_cnt_r <= CNT_ZERO_C;
    end else begin
      state_r    <= state_nxt_s;
      last_r     <= last_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
    end
  end

  // Next-state: enter a burst on a locked grant, count it, release on cap or lock drop.
  always_comb begin
    state_nxt_s    = state_r;
    last_nxt_s     = last_r;
    lock_cnt_nxt_s = lock_cnt_r;
    if (gnt_any_s) begin
      last_nxt_s = gnt_port_s;
    end else begin
      last_nxt_s = last_r;
    end
    case (state_r)
      OWN0, OWN1: begin
        if (!own_lock_s) begin
          state_nxt_s    = IDLE;
          lock_cnt_nxt_s = CNT_ZERO_C;
        end else if (gnt_any_s && ((lock_cnt_r + CNT_ONE_C) == CNT_MAX_C)) begin
          state_nxt_s    = IDLE;
          lock_cnt_nxt_s = CNT_ZERO_C;
        end else if (gnt_any_s) begin
          state_nxt_s    = state_r;
          lock_cnt_nxt_s = lock_cnt_r + CNT_ONE_C;
        end else begin
          state_nxt_s    = state_r;
          lock_cnt_nxt_s = lock_cnt_r;
        end
      end
      default: begin
        if (gnt_any_s && gnt_lock_s && LOCK_EN_C) begin
          state_nxt_s    = (gnt_port_s == DM_ARB_P1) ? OWN1 : OWN0;
          lock_cnt_nxt_s = CNT_ONE_C;
        end else begin
          state_nxt_s    = IDLE;
          lock_cnt_nxt_s = CNT_ZERO_C;
        end
      end
    endcase
  end

  // Output decode: grants and the same-cycle DM access, all quiet in reset.
  always_comb begin
    p0_gnt   = 1'b0;
    p1_gnt   = 1'b0;
    dm_addr  = {ADDR_W{1'b0}};
    dm_wdata = {DATA_W{1'b0}};
    dm_re    = 1'b0;
    dm_we    = 1'b0;
    if (rst) begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
    end else begin
      p0_gnt   = gnt0_s;
      p1_gnt   = gnt1_s;
      dm_addr  = gnt1_s ? p1_addr : p0_addr;
      dm_wdata = gnt1_s ? p1_wdata : p0_wdata;
      dm_re    = gnt_any_s & ~gnt_we_s;
      dm_we    = gnt_any_s & gnt_we_s;
    end
  end

  // Read return: capture DM data at the end of a read grant, one-cycle valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= {DATA_W{1'b0}};
      p1_rdata  <= {DATA_W{1'b0}};
    end else begin
      p0_rvalid <= gnt0_s & ~p0_we;
      p1_rvalid <= gnt1_s & ~p1_we;
      if (gnt0_s && !p0_we) begin
        p0_rdata <= dm_rdata;
      end
      if (gnt1_s && !p1_we) begin
        p1_rdata <= dm_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_arb.sv
// Randomized scoreboard bench for dm_arb with a transaction-level arbitration model.
module tb_dm_arb;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int MAX_LOCK = 4;
`ifdef DM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [ADDR_W-1:0] p0_addr, p1_addr, dm_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, dm_wdata, dm_rdata;
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, dm_re, dm_we;

  always #5 clk = ~clk;

  dm_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .dm_addr(dm_addr), .dm_re(dm_re),
    .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  // Memory behind the arbiter: combinational read, write at the clock edge.
  logic [DATA_W-1:0] dm_mem [0:65535];
  assign dm_rdata = dm_mem[dm_addr];
  always @(posedge clk) if (dm_we) dm_mem[dm_addr] <= dm_wdata;

  // Reference state: pending transactions, burst ownership, expected memory.
  bit          pend[2], t_we[2], t_lock[2];
  logic [15:0] t_addr[2], t_wdata[2];
  logic [15:0] ref_mem [0:255];
  int          owner = -1, burst = 0, last_port = 1;
  logic [15:0] exp_q0[$], exp_q1[$];
  int          checks = 0, passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic txn(input int p, input bit we, input bit lock, input logic [15:0] a, input logic [15:0] d);
    pend[p] = 1'b1; t_we[p] = we; t_lock[p] = lock; t_addr[p] = a; t_wdata[p] = d;
  endtask

  task automatic step(input bit r);
    int g;
    bit lk[2];
    bit exp_re, exp_we;
    logic [15:0] ea;
    @(negedge clk);
    rst = r;
    lk[0] = pend[0] & t_lock[0];
    lk[1] = pend[1] & t_lock[1];
    p0_req = pend[0]; p0_we = t_we[0]; p0_lock = lk[0]; p0_addr = t_addr[0]; p0_wdata = t_wdata[0];
    p1_req = pend[1]; p1_we = t_we[1]; p1_lock = lk[1]; p1_addr = t_addr[1]; p1_wdata = t_wdata[1];
    #1;
    if (r) g = -1;
    else if (owner >= 0) g = pend[owner] ? owner : -1;
    else if (pend[0] && pend[1]) g = FIXED ? 0 : 1 - last_port;
    else if (pend[0]) g = 0;
    else if (pend[1]) g = 1;
    else g = -1;
    exp_re = (g >= 0) && !t_we[g];
    exp_we = (g >= 0) && t_we[g];
    ea = r ? 16'h0000 : ((g >= 0) ? t_addr[g] : t_addr[0]);
    chk("gnt", {30'd0, p1_gnt, p0_gnt}, (g < 0) ? 32'd0 : ((g == 0) ? 32'd1 : 32'd2));
    chk("dm_we_re", {30'd0, dm_we, dm_re}, {30'd0, exp_we, exp_re});
    chk("dm_addr", 32'(dm_addr), 32'(ea));
    if (exp_we) chk("dm_wdata", 32'(dm_wdata), 32'(t_wdata[g]));
    if (r) begin
      owner = -1; burst = 0; last_port = 1;
    end else begin
      if (g >= 0) begin
        if (t_we[g]) ref_mem[t_addr[g][7:0]] = t_wdata[g];
        else if (g == 0) exp_q0.push_back(ref_mem[t_addr[g][7:0]]);
        else exp_q1.push_back(ref_mem[t_addr[g][7:0]]);
        last_port = g;
      end
      if (owner >= 0) begin
        if (!lk[owner]) begin owner = -1; burst = 0; end
        else if (g >= 0) begin
          burst++;
          if (burst == MAX_LOCK) begin owner = -1; burst = 0; end
        end
      end else if (g >= 0 && lk[g] && MAX_LOCK > 1) begin
        owner = g; burst = 1;
      end
      if (g >= 0) pend[g] = 1'b0;
    end
  endtask

  // Monitor: every read response must match the oldest expected one for that port.
  always @(negedge clk) begin
    chk("p0_rvalid", 32'(p0_rvalid), 32'(exp_q0.size() != 0));
    if (p0_rvalid && exp_q0.size() != 0) chk("p0_rdata", 32'(p0_rdata), 32'(exp_q0.pop_front()));
    else if (exp_q0.size() != 0) void'(exp_q0.pop_front());
    chk("p1_rvalid", 32'(p1_rvalid), 32'(exp_q1.size() != 0));
    if (p1_rvalid && exp_q1.size() != 0) chk("p1_rdata", 32'(p1_rdata), 32'(exp_q1.pop_front()));
    else if (exp_q1.size() != 0) void'(exp_q1.pop_front());
  end

  task automatic drain();
    for (int k = 0; k < 12 && (pend[0] || pend[1]); k++) step(1'b0);
    step(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = 16'h0; p0_wdata = 16'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = 16'h0; p1_wdata = 16'h0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; t_we[i] = 1'b0; t_lock[i] = 1'b0; t_addr[i] = 16'h0; t_wdata[i] = 16'h0;
    end
    for (int i = 0; i < 256; i++) begin
      dm_mem[i] <= 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    dm_mem[16'h0010] <= 16'hBEEF;
    ref_mem[8'h10] = 16'hBEEF;

    // Reset, with requests pending that must not be granted.
    step(1'b1);
    txn(0, 1'b1, 1'b0, 16'h0008, 16'h5555);
    txn(1, 1'b0, 1'b1, 16'h0009, 16'h0000);
    step(1'b1);
    @(posedge clk); #1;
    chk("rst_p0_rdata", 32'(p0_rdata), 32'd0);
    chk("rst_p1_rdata", 32'(p1_rdata), 32'd0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    step(1'b1);

    // Single read of a preloaded word.
    txn(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    step(1'b0); step(1'b0);

    // Tie after reset: p0 write first, then p1 reads the written value.
    step(1'b1);
    txn(0, 1'b1, 1'b0, 16'h0004, 16'h1234);
    txn(1, 1'b0, 1'b0, 16'h0004, 16'h0000);
    step(1'b0); step(1'b0); step(1'b0);

    // Continuous requests on both ports.
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p]) txn(p, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom_range(0, 15)), 16'($urandom));
      step(1'b0);
    end
    drain();

    // Lock cap: p1 locked reads with p0 waiting throughout.
    txn(1, 1'b0, 1'b1, 16'h0020, 16'h0000);
    step(1'b0);
    txn(0, 1'b0, 1'b0, 16'h0030, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      if (!pend[1]) txn(1, 1'b0, 1'b1, 16'h0021 + 16'(i), 16'h0000);
      step(1'b0);
    end
    drain();

    // Lock release: p1 stops after two locked grants.
    txn(1, 1'b1, 1'b1, 16'h0040, 16'hA5A5);
    step(1'b0);
    txn(0, 1'b0, 1'b0, 16'h0040, 16'h0000);
    txn(1, 1'b1, 1'b1, 16'h0041, 16'h5A5A);
    step(1'b0); step(1'b0); step(1'b0);
    drain();

    // Reset in the middle of a locked p1 read burst.
    txn(1, 1'b0, 1'b1, 16'h0040, 16'h0000);
    step(1'b0);
    txn(1, 1'b0, 1'b1, 16'h0041, 16'h0000);
    step(1'b1);
    @(posedge clk); #1;
    chk("midburst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    chk("midburst_p1_rdata", 32'(p1_rdata), 32'd0);
    drain();

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 9) < 6)
          txn(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 16'($urandom_range(0, 15)), 16'($urandom));
      step($urandom_range(0, 199) == 0);
    end
    drain();
    step(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
